// File: rtl/pp_shift_accum.sv
// Shift-and-accumulate engine for partial products. Accepts one operand per
// beat with a runtime left shift, sums the shifted terms modulo 2^(2*RADIX),
// and presents the sum once the group closes (in_last or MAX_TERMS reached).
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   clear               synchronous abort of the current group
//   in_valid/in_ready   operand beat handshake
//   in_data, in_shift   operand and its left-shift amount
//   in_last             beat closes the group
//   out_valid/out_ready result handshake
//   out_res             accumulated sum, mod 2^ACC_W
//   out_terms           number of terms in the group
//   out_ovf             sticky overflow for the group
module pp_shift_accum #(
    parameter int unsigned SIZE      = 45,
    parameter int unsigned RADIX     = 54,
    parameter int unsigned MAX_TERMS = 8,
    parameter int unsigned SH_W      = 7,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIZE-1:0]      in_data,
    input  logic [SH_W-1:0]      in_shift,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*RADIX-1:0]   out_res,
    output logic [CNT_W-1:0]     out_terms,
    output logic                 out_ovf
);

    localparam int unsigned ACC_W  = 2 * RADIX;
    // Wide enough to hold every bit of in_data at the largest possible shift.
    localparam int unsigned WIDE_W = SIZE + (1 << SH_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [ACC_W-1:0]   acc, acc_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               ovf, ovf_d;
    logic               in_ready_d, out_valid_d;

    logic [WIDE_W-1:0]  wide;
    logic [ACC_W-1:0]   sh;
    logic               sh_ovf;
    logic [ACC_W:0]     sum;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;
    logic               closing;

    // Shifted operand; any set bit at or above ACC_W flags overflow.
    assign wide    = WIDE_W'(in_data) << in_shift;
    assign sh      = wide[ACC_W-1:0];
    assign sh_ovf  = |wide[WIDE_W-1:ACC_W];
    assign sum     = {1'b0, acc} + {1'b0, sh};
    assign cnt_inc = cnt + CNT_W'(1);
    assign accept  = in_valid & in_ready;
    assign closing = in_last || (cnt_inc == CNT_W'(MAX_TERMS));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            ovf   <= ovf_d;
        end
    end

    // Next state and next datapath values; clear beats any handshake.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        ovf_d   = ovf;
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc_d   = sh;
                        cnt_d   = CNT_W'(1);
                        ovf_d   = sh_ovf;
                        state_d = (in_last || (MAX_TERMS == 1)) ? S_OUT : S_ACC;
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        acc_d   = sum[ACC_W-1:0];
                        cnt_d   = cnt_inc;
                        ovf_d   = ovf | sh_ovf | sum[ACC_W];
                        state_d = closing ? S_OUT : S_ACC;
                    end
                end
                S_OUT: begin
                    if (out_valid && out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Handshake flags decoded from the next state so they register with it.
    always_comb begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (state_d == S_OUT) begin
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Result fields come straight from the accumulator registers, which hold
    // steady while the result waits in S_OUT.
    assign out_res   = acc;
    assign out_terms = cnt;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_pp_shift_accum.sv
module tb_pp_shift_accum;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [44:0]   in_data;
    logic [6:0]    in_shift;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [107:0]  out_res;
    logic [3:0]    out_terms;
    logic          out_ovf;

    int n_checks = 0;
    int n_errors = 0;

    pp_shift_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_terms (out_terms),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one beat and hold it until accepted (bounded); returns #1 after the accepting edge.
    task automatic send(input logic [44:0] d, input logic [6:0] s, input logic l);
        int n;
        n = 0;
        in_data  = d;
        in_shift = s;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("send_timeout", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Complete the output handshake and confirm the return to idle.
    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle_ovalid"}, 128'(out_valid), 128'd0);
        check({tag, "_idle_iready"}, 128'(in_ready), 128'd1);
    endtask

    task automatic check_res(input string tag, input logic [127:0] res,
                             input logic [3:0] terms, input logic ovf);
        check({tag, "_valid"}, 128'(out_valid), 128'd1);
        check({tag, "_res"},   128'(out_res),   res);
        check({tag, "_terms"}, 128'(out_terms), 128'(terms));
        check({tag, "_ovf"},   128'(out_ovf),   128'(ovf));
    endtask

    logic [127:0] e;

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_iready", 128'(in_ready), 128'd1);
        check("rst_ovalid", 128'(out_valid), 128'd0);
        check("rst_res",    128'(out_res), 128'd0);
        check("rst_terms",  128'(out_terms), 128'd0);
        check("rst_ovf",    128'(out_ovf), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Six single-bit terms at scattered shifts.
        send(45'd1, 7'd0, 1'b0);
        send(45'd1, 7'd18, 1'b0);
        send(45'd1, 7'd36, 1'b0);
        send(45'd1, 7'd27, 1'b0);
        send(45'd1, 7'd45, 1'b0);
        check("g1_no_early_valid", 128'(out_valid), 128'd0);
        send(45'd1, 7'd63, 1'b1);
        e = (128'd1 << 0) + (128'd1 << 18) + (128'd1 << 36) + (128'd1 << 27)
          + (128'd1 << 45) + (128'd1 << 63);
        check_res("g1", e, 4'd6, 1'b0);
        take("g1");

        // Two maximal operands at shift 63: carry out of bit 107.
        send(45'h1FFF_FFFF_FFFF, 7'd63, 1'b0);
        send(45'h1FFF_FFFF_FFFF, 7'd63, 1'b1);
        e = ((128'd1 << 46) - 128'd2) << 63;
        e = e & ((128'd1 << 108) - 128'd1);
        check_res("g2", e, 4'd2, 1'b1);
        take("g2");

        // Forced close after MAX_TERMS, then a stalled 9th beat.
        for (int i = 0; i < 8; i++) send(45'd5, 7'd0, 1'b0);
        check_res("g3", 128'd40, 4'd8, 1'b0);
        check("g3_iready_low", 128'(in_ready), 128'd0);
        in_data  = 45'd3;
        in_shift = 7'd2;
        in_last  = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("g3_stall_iready", 128'(in_ready), 128'd0);
        check_res("g3_stall", 128'd40, 4'd8, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("g3_hs_ovalid", 128'(out_valid), 128'd0);
        check("g3_hs_iready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_res("g4", 128'd12, 4'd1, 1'b0);
        take("g4");

        // Backpressure for 10 cycles.
        send(45'd9, 7'd4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("bp_ovalid", 128'(out_valid), 128'd1);
            check("bp_res",    128'(out_res), 128'd144);
            check("bp_iready", 128'(in_ready), 128'd0);
            @(posedge clk); #1;
        end
        take("bp");

        // Shift overflow and zero-valued term; ovf clears on next group.
        send(45'd1, 7'd108, 1'b0);
        send(45'd0, 7'd120, 1'b1);
        check_res("g5", 128'd0, 4'd2, 1'b1);
        take("g5");
        send(45'd0, 7'd120, 1'b1);
        check_res("g6", 128'd0, 4'd1, 1'b0);
        take("g6");

        // Clear mid-group with a beat offered in the same cycle.
        send(45'd1, 7'd0, 1'b0);
        send(45'd1, 7'd1, 1'b0);
        send(45'd1, 7'd2, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 45'd100;
        in_shift = 7'd0;
        in_last  = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("clr_ovalid", 128'(out_valid), 128'd0);
        check("clr_iready", 128'(in_ready), 128'd1);
        check("clr_terms",  128'(out_terms), 128'd0);
        check("clr_res",    128'(out_res), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        check("clr_no_result", 128'(out_valid), 128'd0);
        send(45'd7, 7'd1, 1'b1);
        check_res("g7", 128'd14, 4'd1, 1'b0);
        take("g7");

        // Reset while a result is pending.
        send(45'd3, 7'd0, 1'b1);
        check("rst2_pre_ovalid", 128'(out_valid), 128'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst2_ovalid", 128'(out_valid), 128'd0);
        check("rst2_iready", 128'(in_ready), 128'd1);
        check("rst2_res",    128'(out_res), 128'd0);
        check("rst2_terms",  128'(out_terms), 128'd0);
        check("rst2_ovf",    128'(out_ovf), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pp_shift_accum.md
Name: pp_shift_accum

Overview:
- Sequential, parametrised successor to the fixed combinational shifted-operand adders used in the wide-multiplier datapath.
- Accepts one partial product per beat, each with a runtime shift amount. Accumulates the shifted values into a 2*RADIX-bit sum.
- Emits the sum when the group's last beat arrives or the term limit is reached.
- Replaces hard-wired operand counts and offsets: the multiplier controller streams partial products of any radix/offset layout.

Parameters:
SIZE, 45, partial-product operand width in bits
RADIX, 54, limb radix; accumulator width ACC_W = 2*RADIX
MAX_TERMS, 8, maximum operands per group; forced close on the MAX_TERMS-th accepted term
SH_W, 7, shift-amount width; must satisfy 2^SH_W >= ACC_W
CNT_W, 4, term-counter width; must satisfy 2^CNT_W > MAX_TERMS

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
clear  input  1  synchronous abort of current group, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat
in_data  input  SIZE  partial-product operand
in_shift  input  SH_W  left-shift applied to in_data
in_last  input  1  beat closes the group
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_res  output  2*RADIX  accumulated sum, mod 2^ACC_W
out_terms  output  CNT_W  number of terms in the group
out_ovf  output  1  sticky overflow for the group

Behaviour:
- Reset and interface rules:
  - Reset is synchronous: when rst_n=0 at a rising edge, the block goes to IDLE. acc=0, cnt=0, ovf=0.
  - All outputs reset to 0, except in_ready, which is 1 after reset.
  - Reset mid-group or mid-output discards all state; no result is emitted.
- FSM states IDLE, ACC and OUT:
  - IDLE: in_ready=1, out_valid=0. An accepted beat (in_valid&in_ready) loads acc = shifted operand, sets cnt=1 and sets ovf from that term. Next state is ACC, or OUT if in_last=1 or MAX_TERMS=1.
  - ACC: in_ready=1. An accepted beat sets acc = acc + shifted operand and cnt = cnt+1. If in_last=1 or cnt+1==MAX_TERMS, next state is OUT; otherwise stay in ACC. With no beat offered, hold.
  - OUT: in_ready=0, out_valid=1. out_res/out_terms/out_ovf are registered and stable until the handshake. On out_valid&out_ready, go to IDLE. Hold indefinitely under backpressure.
- Latency: result is valid on the cycle after the closing beat is accepted. Minimum group period is terms+1 cycles (one bubble for the output handshake).
- Shifted operand = zero-extend(in_data) << in_shift, truncated to ACC_W.
- Overflow:
  - ovf is set if any nonzero in_data bit lands at position >= ACC_W, including in_shift >= ACC_W with in_data != 0.
  - ovf is also set if the ACC_W-bit addition carries out.
  - ovf is sticky for the group and clears on the next group's first beat.
  - Truncated bits are discarded, not saturated.
- Zero-valued operands still count as terms.
- clear=1 (with rst_n=1):
  - Acts next edge: state goes to IDLE, acc/cnt/ovf=0, out_valid drops, no result is emitted.
  - clear has priority over any beat or output handshake in the same cycle.
  - A beat offered in the clear cycle is dropped.
- Priority order: rst_n, then clear, then handshakes.
- in_last while in OUT cannot occur (in_ready=0). Beats offered while in OUT are not accepted and must be held by the source.
- The closing beat needs in_last=1 only if cnt < MAX_TERMS-1. Reaching MAX_TERMS closes the group regardless of in_last.

Test Plan:
- Six beats, in_data=1, shifts 0,18,36,27,45,63, last on 6th -> out_res = 2^0+2^18+2^36+2^27+2^45+2^63, out_terms=6, out_ovf=0, out_valid one cycle after the 6th accept.
- Two beats, in_data=2^45-1, shift 63 then 63 -> out_res = (2^46-2)<<63 mod 2^108, out_ovf=1 (bit 108 lost/carry), out_terms=2.
- 8 beats of in_data=5, shift 0, in_last never asserted -> forced close after 8th; out_res=40, out_terms=8; 9th beat stalls (in_ready=0) until the out handshake, then starts a new group.
- out_ready held low 10 cycles after result -> out_valid/out_res stable, in_ready=0 throughout; single handshake, then back to IDLE.
- 3 beats accepted, then clear=1 with in_valid=1 the same cycle -> no result emitted, beat dropped; next group (in_data=7, shift 1, last) gives out_res=14, out_terms=1.
- rst_n=0 for one cycle while in OUT -> out_valid=0, in_ready=1 the next cycle; out_res/out_terms/out_ovf=0.
